bus_master_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single system bus among NUM_MASTERS requesters
//  (CPU, ACP, VGA, ...). Grants ownership with a req/grant handshake and muxes the

---
 rtl/bus_master_arbiter.sv | 101 ++++++++++
 tb/tb_bus_master_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bus_master_arbiter.sv
// Round-robin bus arbiter: one-hot registered grant, owner address mux and a
// hold-time watchdog that revokes and masks a master that keeps the bus too long.
module bus_master_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int ID_WIDTH    = 2,
   parameter int TIMEOUT     = 255,
   parameter int TO_WIDTH    = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_MASTERS-1:0]            req,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_addr,
   output logic [NUM_MASTERS-1:0]            grant,
   output logic [ID_WIDTH-1:0]               grant_id,
   output logic                              bus_busy,
   output logic [ADDR_WIDTH-1:0]             bus_addr,
   output logic                              bus_timeout
);

   typedef enum logic [1:0] {IDLE, OWNED, PARK} state_t;

   state_t                 state;
   logic [NUM_MASTERS-1:0] mask;
   logic [NUM_MASTERS-1:0] cand;
   logic [ID_WIDTH-1:0]    last_winner;
   logic [ID_WIDTH-1:0]    pick;
   logic                   pick_valid;
   logic [TO_WIDTH-1:0]    count;
   logic                   owner_req;
   int                     idx;

   assign cand      = req & ~mask;
   assign owner_req = |(req & grant);
   assign bus_busy  = |grant;

   // Scan upward from the slot after the last winner so every requester gets a turn.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      idx        = 0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         idx = (int'(last_winner) + i) % NUM_MASTERS;
         if (!pick_valid && cand[idx]) begin
            pick       = ID_WIDTH'(idx);
            pick_valid = 1'b1;
         end
      end
   end

   always_comb begin
      bus_addr = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant[i]) bus_addr = master_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         grant_id    <= '0;
         bus_timeout <= 1'b0;
         count       <= '0;
         mask        <= '0;
         last_winner <= ID_WIDTH'(NUM_MASTERS - 1);
      end else begin
         bus_timeout <= 1'b0;
         mask        <= mask & req;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant       <= NUM_MASTERS'(1) << pick;
                  grant_id    <= pick;
                  last_winner <= pick;
                  count       <= '0;
                  state       <= OWNED;
               end
            end
            OWNED: begin
               if (count != '1) count <= count + 1'b1;
               // A release on the timeout cycle wins: no pulse and no mask.
               if (!owner_req) begin
                  grant    <= '0;
                  grant_id <= '0;
                  state    <= PARK;
               end else if (count == TO_WIDTH'(TIMEOUT - 1)) begin
                  grant       <= '0;
                  grant_id    <= '0;
                  bus_timeout <= 1'b1;
                  mask        <= (mask & req) | grant;
                  state       <= PARK;
               end
            end
            PARK:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter with a short watchdog (TIMEOUT=4).
module tb_bus_master_arbiter;

   localparam logic [31:0] A0 = 32'h0000_1030;
   localparam logic [31:0] A1 = 32'h2000_0104;
   localparam logic [31:0] A2 = 32'h3000_0208;
   localparam logic [31:0] A3 = 32'h4000_030C;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   req = 4'b0000;
   logic [127:0] master_addr;
   logic [3:0]   grant;
   logic [1:0]   grant_id;
   logic         bus_busy;
   logic [31:0]  bus_addr;
   logic         bus_timeout;

   int check_count = 0;
   int fail_count  = 0;

   bus_master_arbiter #(
      .NUM_MASTERS(4),
      .ADDR_WIDTH (32),
      .ID_WIDTH   (2),
      .TIMEOUT    (4),
      .TO_WIDTH   (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .master_addr(master_addr),
      .grant      (grant),
      .grant_id   (grant_id),
      .bus_busy   (bus_busy),
      .bus_addr   (bus_addr),
      .bus_timeout(bus_timeout)
   );

   always #5 clk = ~clk;

   // Drive inputs, let them be sampled at the next rising edge, then settle.
   task automatic applyStimulus(input logic rst_v, input logic [3:0] req_v);
      rst = rst_v;
      req = req_v;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic checkGrant(input string tag, input logic [3:0] g, input logic [1:0] id, input logic [31:0] addr);
      checkOutput({tag, "_grant"}, 32'(grant), 32'(g));
      checkOutput({tag, "_id"}, 32'(grant_id), 32'(id));
      checkOutput({tag, "_busy"}, 32'(bus_busy), 32'(g != 4'b0000));
      checkOutput({tag, "_addr"}, bus_addr, addr);
   endtask

   initial begin
      master_addr = {A3, A2, A1, A0};

      // Test 1: single master grant and release
      applyStimulus(1'b1, 4'b0000);
      checkGrant("rst", 4'b0000, 2'd0, 32'h0);
      checkOutput("rst_timeout", 32'(bus_timeout), 32'h0);
      applyStimulus(1'b0, 4'b0001);
      checkGrant("t1_gnt", 4'b0001, 2'd0, A0);
      applyStimulus(1'b0, 4'b0000);
      checkGrant("t1_rel", 4'b0000, 2'd0, 32'h0);
      applyStimulus(1'b0, 4'b0000);

      // Test 2: round-robin between masters 1 and 2 with PARK gap
      applyStimulus(1'b1, 4'b0000);
      applyStimulus(1'b0, 4'b0110);
      checkGrant("t2_m1", 4'b0010, 2'd1, A1);
      applyStimulus(1'b0, 4'b0110);
      checkGrant("t2_m1_hold", 4'b0010, 2'd1, A1);
      applyStimulus(1'b0, 4'b0100);
      checkGrant("t2_park", 4'b0000, 2'd0, 32'h0);
      applyStimulus(1'b0, 4'b0100);
      checkGrant("t2_idle", 4'b0000, 2'd0, 32'h0);
      applyStimulus(1'b0, 4'b0100);
      checkGrant("t2_m2", 4'b0100, 2'd2, A2);
      applyStimulus(1'b0, 4'b0110);
      checkGrant("t2_nopreempt", 4'b0100, 2'd2, A2);
      applyStimulus(1'b0, 4'b0010);
      checkGrant("t2_park2", 4'b0000, 2'd0, 32'h0);
      applyStimulus(1'b0, 4'b0010);
      checkGrant("t2_idle2", 4'b0000, 2'd0, 32'h0);
      applyStimulus(1'b0, 4'b0010);
      checkGrant("t2_m1_again", 4'b0010, 2'd1, A1);
      applyStimulus(1'b0, 4'b0000);
      applyStimulus(1'b0, 4'b0000);

      // Test 3: all masters requesting, each releases after 3 cycles
      applyStimulus(1'b1, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         logic [3:0]  oh;
         logic [31:0] ad;
         oh = 4'b0001 << (k % 4);
         ad = master_addr[(k % 4)*32 +: 32];
         applyStimulus(1'b0, 4'b1111);
         checkGrant($sformatf("t3_own%0d_c1", k), oh, 2'(k % 4), ad);
         applyStimulus(1'b0, 4'b1111);
         checkGrant($sformatf("t3_own%0d_c2", k), oh, 2'(k % 4), ad);
         applyStimulus(1'b0, 4'b1111);
         checkGrant($sformatf("t3_own%0d_c3", k), oh, 2'(k % 4), ad);
         applyStimulus(1'b0, 4'b1111 & ~oh);
         checkGrant($sformatf("t3_park%0d", k), 4'b0000, 2'd0, 32'h0);
         applyStimulus(1'b0, 4'b1111);
         checkGrant($sformatf("t3_idle%0d", k), 4'b0000, 2'd0, 32'h0);
      end
      applyStimulus(1'b0, 4'b0000);

      // Test 4: watchdog revokes master 2 after 4 cycles and masks it
      applyStimulus(1'b1, 4'b0000);
      applyStimulus(1'b0, 4'b0100);
      checkGrant("t4_c1", 4'b0100, 2'd2, A2);
      checkOutput("t4_c1_to", 32'(bus_timeout), 32'h0);
      applyStimulus(1'b0, 4'b0100);
      checkGrant("t4_c2", 4'b0100, 2'd2, A2);
      applyStimulus(1'b0, 4'b1100);
      checkGrant("t4_c3", 4'b0100, 2'd2, A2);
      applyStimulus(1'b0, 4'b1100);
      checkGrant("t4_c4", 4'b0100, 2'd2, A2);
      checkOutput("t4_c4_to", 32'(bus_timeout), 32'h0);
      applyStimulus(1'b0, 4'b1100);
      checkGrant("t4_revoke", 4'b0000, 2'd0, 32'h0);
      checkOutput("t4_pulse", 32'(bus_timeout), 32'h1);
      applyStimulus(1'b0, 4'b1100);
      checkOutput("t4_pulse_end", 32'(bus_timeout), 32'h0);
      checkGrant("t4_idle", 4'b0000, 2'd0, 32'h0);
      applyStimulus(1'b0, 4'b1100);
      checkGrant("t4_m3", 4'b1000, 2'd3, A3);
      applyStimulus(1'b0, 4'b0100);
      checkGrant("t4_park", 4'b0000, 2'd0, 32'h0);
      applyStimulus(1'b0, 4'b0100);
      applyStimulus(1'b0, 4'b0100);
      checkGrant("t4_masked1", 4'b0000, 2'd0, 32'h0);
      applyStimulus(1'b0, 4'b0100);
      checkGrant("t4_masked2", 4'b0000, 2'd0, 32'h0);
      applyStimulus(1'b0, 4'b0000);
      checkGrant("t4_drop", 4'b0000, 2'd0, 32'h0);
      applyStimulus(1'b0, 4'b0100);
      checkGrant("t4_unmasked", 4'b0100, 2'd2, A2);
      applyStimulus(1'b0, 4'b0000);
      applyStimulus(1'b0, 4'b0000);

      // Test 5: reset in the middle of an ownership
      applyStimulus(1'b1, 4'b0000);
      applyStimulus(1'b0, 4'b0100);
      checkGrant("t5_m2", 4'b0100, 2'd2, A2);
      applyStimulus(1'b0, 4'b0100);
      applyStimulus(1'b1, 4'b0100);
      checkGrant("t5_rst", 4'b0000, 2'd0, 32'h0);
      checkOutput("t5_rst_to", 32'(bus_timeout), 32'h0);
      applyStimulus(1'b0, 4'b0110);
      checkGrant("t5_prio", 4'b0010, 2'd1, A1);
      applyStimulus(1'b0, 4'b0000);
      applyStimulus(1'b0, 4'b0000);

      // Test 6: long idle stretch
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b0, 4'b0000);
         checkGrant($sformatf("t6_idle%0d", k), 4'b0000, 2'd0, 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule
